// File: rtl/tb_l2_mp_behavior_ram.sv
// ---------------------------------------------------------------------------
// tb_l2_mp_behavior_ram
//
// Behavioural multi-port L2 memory model. Several requester channels share one
// RAM of SIZE lines. Exactly one channel is granted per cycle, round-robin.
// Reads return after a fixed latency through a shared, strictly ordered
// response queue. Writes are byte-enabled and produce no response.
//
// Ports
//   i_clk, i_reset      clock; synchronous active-high reset
//   i_req_valid[n]      request valid per channel
//   i_req_cmd[n]        M_XWR = write, anything else is treated as a read
//   i_req_addr[n]       byte address
//   i_req_tag[n]        tag echoed back on the read response
//   i_req_data[n]       write data (one full line)
//   i_req_byte_en[n]    write byte enables
//   o_req_ready[n]      accept, only ever asserted for the granted channel
//   o_resp_valid[n]     read response valid, only for the queue head channel
//   o_resp_tag[n]       queue head tag (same value on every channel)
//   o_resp_data[n]      queue head data (same value on every channel)
//   i_resp_ready[n]     response accept per channel
//   o_addr_err          sticky flag: an accepted request was out of range
// ---------------------------------------------------------------------------
module tb_l2_mp_behavior_ram #(
  parameter int                REQ_N        = 2,
  parameter int                DATA_W       = 512,
  parameter int                TAG_W        = 8,
  parameter int                ADDR_W       = 56,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h8000_0000,
  parameter int                SIZE         = 4096,
  parameter int                RD_LAT       = 10,
  parameter int                RESP_Q_DEPTH = 8
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [REQ_N-1:0]                 i_req_valid,
  input  logic [REQ_N-1:0][4:0]            i_req_cmd,
  input  logic [REQ_N-1:0][ADDR_W-1:0]     i_req_addr,
  input  logic [REQ_N-1:0][TAG_W-1:0]      i_req_tag,
  input  logic [REQ_N-1:0][DATA_W-1:0]     i_req_data,
  input  logic [REQ_N-1:0][DATA_W/8-1:0]   i_req_byte_en,
  output logic [REQ_N-1:0]                 o_req_ready,
  output logic [REQ_N-1:0]                 o_resp_valid,
  output logic [REQ_N-1:0][TAG_W-1:0]      o_resp_tag,
  output logic [REQ_N-1:0][DATA_W-1:0]     o_resp_data,
  input  logic [REQ_N-1:0]                 i_resp_ready,
  output logic                             o_addr_err
);

  localparam logic [4:0] M_XWR = 5'b00001;

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(SIZE);
  localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int QP_W  = $clog2(RESP_Q_DEPTH);
  localparam int CNT_W = $clog2(RESP_Q_DEPTH + 1);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(SIZE) * ADDR_W'(BYTES);

  typedef struct packed {
    logic [PTR_W-1:0]  ch;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rd_ent_t;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  cand;
  logic              gnt_v;
  logic              gnt_wr;
  logic [ADDR_W-1:0] gnt_addr;
  logic [ADDR_W-1:0] gnt_off;
  logic              gnt_in_range;
  logic [IDX_W-1:0]  gnt_line;
  logic              reset_q;
  logic              block_req;
  logic              rd_credit;
  logic              ready_g;
  logic              acc;
  logic              rd_acc;
  logic              wr_acc;
  logic [CNT_W-1:0]  outstanding;
  logic [DATA_W-1:0] rd_data;
  rd_ent_t           s0;
  logic              push_v;
  rd_ent_t           push_e;
  rd_ent_t           head;
  logic              pop;
  logic              q_empty;
  logic              q_full;
  logic [QP_W-1:0]   q_wr;
  logic [QP_W-1:0]   q_rd;
  logic [CNT_W-1:0]  q_cnt;

  logic [DATA_W-1:0] ram [SIZE];
  rd_ent_t           q_mem [RESP_Q_DEPTH];

  // First valid channel at or after the round-robin pointer wins the grant,
  // whether or not it can actually be accepted this cycle.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < REQ_N; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % REQ_N);
      if (!gnt_v && i_req_valid[cand]) begin
        gnt_v   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign gnt_wr       = (i_req_cmd[gnt_idx] == M_XWR);
  assign gnt_addr     = i_req_addr[gnt_idx];
  assign gnt_off      = gnt_addr - BASE_ADDR;
  assign gnt_in_range = (gnt_addr >= BASE_ADDR) && (gnt_off < SPAN);
  assign gnt_line     = gnt_off[OFF_W +: IDX_W];

  // Credit counts every read still owed a response (pipeline plus queue), so
  // the queue can never overflow. A pop only frees credit on the next cycle.
  assign rd_credit = (outstanding < CNT_W'(RESP_Q_DEPTH));
  assign block_req = i_reset || reset_q;
  assign ready_g   = gnt_v && !block_req && (gnt_wr || rd_credit);
  assign acc       = ready_g;
  assign rd_acc    = acc && !gnt_wr;
  assign wr_acc    = acc && gnt_wr && gnt_in_range;

  always_comb begin
    o_req_ready          = '0;
    o_req_ready[gnt_idx] = ready_g;
  end

  // Requests are held off for one extra cycle after reset is released.
  always_ff @(posedge i_clk) begin
    reset_q <= i_reset;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_ptr     <= '0;
      o_addr_err <= 1'b0;
    end else if (acc) begin
      rr_ptr <= PTR_W'((int'(gnt_idx) + 1) % REQ_N);
      if (!gnt_in_range) o_addr_err <= 1'b1;
    end
  end

  // RAM is deliberately left out of reset so preloaded contents survive.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BYTES; b++) begin
        if (i_req_byte_en[gnt_idx][b]) ram[gnt_line][b*8 +: 8] <= i_req_data[gnt_idx][b*8 +: 8];
      end
    end
  end

  // The RAM is sampled in the acceptance cycle; out-of-range reads return zero.
  assign rd_data = gnt_in_range ? ram[gnt_line] : '0;
  assign s0      = '{ch: gnt_idx, tag: i_req_tag[gnt_idx], data: rd_data};

  // RD_LAT-1 register stages; the queue write adds the final cycle, so a read
  // accepted in cycle t heads an empty queue in cycle t+RD_LAT.
  if (RD_LAT == 1) begin : g_no_pipe
    assign push_v = rd_acc;
    assign push_e = s0;
  end else begin : g_pipe
    logic [RD_LAT-2:0] pv;
    rd_ent_t           pe [RD_LAT-1];

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        pv <= '0;
      end else begin
        pv[0] <= rd_acc;
        for (int s = 1; s < RD_LAT - 1; s++) pv[s] <= pv[s-1];
      end
    end

    always_ff @(posedge i_clk) begin
      pe[0] <= s0;
      for (int s = 1; s < RD_LAT - 1; s++) pe[s] <= pe[s-1];
    end

    assign push_v = pv[RD_LAT-2];
    assign push_e = pe[RD_LAT-2];
  end

  assign q_empty = (q_cnt == '0);
  assign q_full  = (q_cnt == CNT_W'(RESP_Q_DEPTH));
  assign head    = q_mem[q_rd];
  assign pop     = !q_empty && !i_reset && i_resp_ready[head.ch];

  // Circular FIFO; a push while full is only ever paired with a pop, and then
  // overwrites the slot being popped this same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q_wr        <= '0;
      q_rd        <= '0;
      q_cnt       <= '0;
      outstanding <= '0;
    end else begin
      if (push_v) q_wr <= q_wr + QP_W'(1);
      if (pop)    q_rd <= q_rd + QP_W'(1);
      case ({push_v, pop})
        2'b10:   q_cnt <= q_cnt + CNT_W'(1);
        2'b01:   q_cnt <= q_cnt - CNT_W'(1);
        default: q_cnt <= q_cnt;
      endcase
      case ({rd_acc, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_v) q_mem[q_wr] <= push_e;
  end

  // Only the queue head is visible; tag and data are broadcast to all channels.
  always_comb begin
    o_resp_valid = '0;
    for (int c = 0; c < REQ_N; c++) begin
      o_resp_tag[c]  = '0;
      o_resp_data[c] = '0;
    end
    if (!q_empty && !i_reset) begin
      o_resp_valid[head.ch] = 1'b1;
      for (int c = 0; c < REQ_N; c++) begin
        o_resp_tag[c]  = head.tag;
        o_resp_data[c] = head.data;
      end
    end
  end

  a_no_overflow : assert property (@(posedge i_clk) disable iff (i_reset) !(push_v && q_full && !pop))
    else $error("response queue overflow");

endmodule

// File: tb/tb_tb_l2_mp_behavior_ram.sv
// ---------------------------------------------------------------------------
// tb_tb_l2_mp_behavior_ram
//
// Bench for tb_l2_mp_behavior_ram with two channels, RD_LAT=10 and a
// four-deep response queue. Read expectations go into a scoreboard queue at
// acceptance; a negedge monitor compares the response head against it.
// ---------------------------------------------------------------------------
module tb_tb_l2_mp_behavior_ram;

  localparam int REQ_N   = 2;
  localparam int DATA_W  = 512;
  localparam int TAG_W   = 8;
  localparam int ADDR_W  = 56;
  localparam int BE_W    = DATA_W / 8;
  localparam int RD_LAT  = 10;
  localparam int Q_DEPTH = 4;
  localparam int NV      = 11;

  localparam logic [4:0] M_XRD = 5'b00000;
  localparam logic [4:0] M_XWR = 5'b00001;

  logic                          i_clk = 1'b0;
  logic                          i_reset;
  logic [REQ_N-1:0]              i_req_valid;
  logic [REQ_N-1:0][4:0]         i_req_cmd;
  logic [REQ_N-1:0][ADDR_W-1:0]  i_req_addr;
  logic [REQ_N-1:0][TAG_W-1:0]   i_req_tag;
  logic [REQ_N-1:0][DATA_W-1:0]  i_req_data;
  logic [REQ_N-1:0][BE_W-1:0]    i_req_byte_en;
  logic [REQ_N-1:0]              o_req_ready;
  logic [REQ_N-1:0]              o_resp_valid;
  logic [REQ_N-1:0][TAG_W-1:0]   o_resp_tag;
  logic [REQ_N-1:0][DATA_W-1:0]  o_resp_data;
  logic [REQ_N-1:0]              i_resp_ready;
  logic                          o_addr_err;

  tb_l2_mp_behavior_ram #(
    .REQ_N(REQ_N), .DATA_W(DATA_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W),
    .BASE_ADDR(56'h8000_0000), .SIZE(4096), .RD_LAT(RD_LAT), .RESP_Q_DEPTH(Q_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .i_req_cmd(i_req_cmd), .i_req_addr(i_req_addr),
    .i_req_tag(i_req_tag), .i_req_data(i_req_data), .i_req_byte_en(i_req_byte_en),
    .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid), .o_resp_tag(o_resp_tag),
    .o_resp_data(o_resp_data), .i_resp_ready(i_resp_ready), .o_addr_err(o_addr_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int                ch;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    int                cyc;
    bit                chk_lat;
  } sb_t;

  typedef struct {
    int                ch;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] exp;
    bit                err;
  } vec_t;

  sb_t  sb [$];
  sb_t  m_e;
  sb_t  p_e;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_errors = 0;
  int last_ch  = 1;
  int accepts;
  int n;
  int g_ch;
  int exp_ch;
  logic [REQ_N-1:0] got;
  logic             acc_b;

  localparam logic [DATA_W-1:0] D_AB   = {64{8'hAB}};
  localparam logic [DATA_W-1:0] D_PART = {{60{8'h11}}, {4{8'hFF}}};

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input int ch, input bit wr, input logic [ADDR_W-1:0] addr,
                                 input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] wdata,
                                 input logic [BE_W-1:0] be, input logic [DATA_W-1:0] exp, input bit err);
    vec_t v;
    v.ch = ch; v.wr = wr; v.addr = addr; v.tag = tag;
    v.wdata = wdata; v.be = be; v.exp = exp; v.err = err;
    return v;
  endfunction

  function automatic void sbPush(input int ch, input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data, input bit chk_lat);
    sb_t e;
    e.ch = ch; e.tag = tag; e.data = data; e.cyc = cyc; e.chk_lat = chk_lat;
    sb.push_back(e);
  endfunction

  // Present one request on a channel and hold it until accepted (bounded).
  // Called and returns at posedge+1.
  task automatic applyStimulus(input int ch, input bit wr, input logic [ADDR_W-1:0] addr,
                               input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] wdata,
                               input logic [BE_W-1:0] be, input logic [DATA_W-1:0] exp, input bit chk_lat);
    bit acc = 1'b0;
    int k = 0;
    i_req_valid[ch]   = 1'b1;
    i_req_cmd[ch]     = wr ? M_XWR : M_XRD;
    i_req_addr[ch]    = addr;
    i_req_tag[ch]     = tag;
    i_req_data[ch]    = wdata;
    i_req_byte_en[ch] = be;
    while (!acc && k < 100) begin
      @(negedge i_clk);
      if (o_req_ready[ch]) begin
        acc = 1'b1;
        last_ch = ch;
        if (!wr) sbPush(ch, tag, exp, chk_lat);
      end
      @(posedge i_clk); #1;
      k++;
    end
    i_req_valid[ch] = 1'b0;
    checkOutput("req_accepted", DATA_W'(acc), DATA_W'(1));
  endtask

  task automatic waitDrain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge i_clk); #1;
      k++;
    end
    checkOutput("sb_drained", DATA_W'(sb.size()), '0);
  endtask

  // Response monitor: head must match the oldest expected read, stay stable
  // while stalled, and arrive exactly RD_LAT after acceptance when flagged.
  always @(negedge i_clk) begin
    if (!i_reset && o_resp_valid != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", DATA_W'(o_resp_valid), '0);
      end else begin
        m_e = sb[0];
        checkOutput("resp_valid", DATA_W'(o_resp_valid), DATA_W'(1) << m_e.ch);
        checkOutput("resp_tag", DATA_W'(o_resp_tag[m_e.ch]), DATA_W'(m_e.tag));
        checkOutput("resp_tag_bcast", DATA_W'(o_resp_tag[(m_e.ch + 1) % REQ_N]), DATA_W'(m_e.tag));
        checkOutput("resp_data", o_resp_data[m_e.ch], m_e.data);
        if (m_e.chk_lat) begin
          checkOutput("resp_latency", DATA_W'(cyc - m_e.cyc), DATA_W'(RD_LAT));
          m_e.chk_lat = 1'b0;
          sb[0] = m_e;
        end
        if (i_resp_ready[m_e.ch]) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mkVec(0, 1'b1, 56'h8000_0040, 8'h00, D_AB,          '1,      '0,     1'b0);
    vecs[1]  = mkVec(0, 1'b0, 56'h8000_0040, 8'h03, '0,            '0,      D_AB,   1'b0);
    vecs[2]  = mkVec(1, 1'b1, 56'h8000_0000, 8'h00, {64{8'h11}},   '1,      '0,     1'b0);
    vecs[3]  = mkVec(1, 1'b1, 56'h8000_0000, 8'h00, {64{8'hFF}},   64'h0F,  '0,     1'b0);
    vecs[4]  = mkVec(0, 1'b0, 56'h8000_0000, 8'h05, '0,            '0,      D_PART, 1'b0);
    vecs[5]  = mkVec(1, 1'b1, 56'h8003_FFC0, 8'h00, {64{8'h5A}},   '1,      '0,     1'b0);
    vecs[6]  = mkVec(1, 1'b0, 56'h8003_FFC0, 8'h07, '0,            '0,      {64{8'h5A}}, 1'b0);
    vecs[7]  = mkVec(1, 1'b0, 56'h8000_0047, 8'h09, '0,            '0,      D_AB,   1'b0);
    vecs[8]  = mkVec(0, 1'b1, 56'h8004_0000, 8'h00, {64{8'hEE}},   '1,      '0,     1'b1);
    vecs[9]  = mkVec(1, 1'b0, 56'h8000_0000, 8'h0B, '0,            '0,      D_PART, 1'b1);
    vecs[10] = mkVec(0, 1'b0, 56'h7FFF_FFC0, 8'h0C, '0,            '0,      '0,     1'b1);

    i_reset       = 1'b1;
    i_req_valid   = '0;
    i_req_cmd     = '0;
    i_req_addr    = '0;
    i_req_tag     = '0;
    i_req_data    = '0;
    i_req_byte_en = '0;
    i_resp_ready  = '1;
    i_req_valid[0] = 1'b1;
    i_req_addr[0]  = 56'h8000_0040;

    // Reset state, including the cycle after release.
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_req_ready", DATA_W'(o_req_ready), '0);
    checkOutput("rst_resp_valid", DATA_W'(o_resp_valid), '0);
    checkOutput("rst_resp_tag", DATA_W'(o_resp_tag), '0);
    checkOutput("rst_resp_data", o_resp_data[0], '0);
    checkOutput("rst_addr_err", DATA_W'(o_addr_err), '0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    checkOutput("post_rst_req_ready", DATA_W'(o_req_ready), '0);
    @(posedge i_clk); #1;
    i_req_valid = '0;

    // Table-driven single transactions.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].tag, vecs[i].wdata,
                    vecs[i].be, vecs[i].exp, !vecs[i].wr);
      waitDrain(50);
      @(negedge i_clk);
      checkOutput($sformatf("vec%0d_addr_err", i), DATA_W'(o_addr_err), DATA_W'(vecs[i].err));
      @(posedge i_clk); #1;
    end

    // Both channels reading every cycle: grants must alternate.
    exp_ch = (last_ch + 1) % REQ_N;
    for (int c = 0; c < REQ_N; c++) begin
      i_req_valid[c] = 1'b1;
      i_req_cmd[c]   = M_XRD;
      i_req_addr[c]  = 56'h8000_0040;
    end
    i_req_tag[0] = 8'h40;
    i_req_tag[1] = 8'h50;
    accepts = 0;
    n = 0;
    while (accepts < 6 && n < 200) begin
      @(negedge i_clk);
      got  = o_req_ready & i_req_valid;
      g_ch = -1;
      if (got != '0) begin
        g_ch = got[1] ? 1 : 0;
        checkOutput("rr_grant", DATA_W'(got), DATA_W'(1) << exp_ch);
        sbPush(g_ch, i_req_tag[g_ch], D_AB, 1'b0);
        accepts++;
        last_ch = g_ch;
        exp_ch  = (g_ch + 1) % REQ_N;
      end
      @(posedge i_clk); #1;
      n++;
      if (g_ch >= 0) i_req_tag[g_ch] = i_req_tag[g_ch] + 8'd1;
    end
    i_req_valid = '0;
    checkOutput("rr_accepts", DATA_W'(accepts), DATA_W'(6));
    waitDrain(200);

    // Credit exhaustion with responses stalled; writes still pass.
    i_resp_ready   = '0;
    i_req_valid[0] = 1'b1;
    i_req_cmd[0]   = M_XRD;
    i_req_addr[0]  = 56'h8000_0040;
    i_req_tag[0]   = 8'h60;
    accepts = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge i_clk);
      acc_b = o_req_ready[0];
      if (acc_b) begin
        sbPush(0, i_req_tag[0], D_AB, 1'b0);
        accepts++;
        last_ch = 0;
      end
      @(posedge i_clk); #1;
      if (acc_b) i_req_tag[0] = i_req_tag[0] + 8'd1;
    end
    checkOutput("credit_accepts", DATA_W'(accepts), DATA_W'(Q_DEPTH));
    @(negedge i_clk);
    checkOutput("credit_ready_low", DATA_W'(o_req_ready[0]), '0);
    @(posedge i_clk); #1;
    i_req_cmd[0]     = M_XWR;
    i_req_addr[0]    = 56'h8000_0280;
    i_req_data[0]    = {64{8'hC3}};
    i_req_byte_en[0] = '1;
    @(negedge i_clk);
    checkOutput("credit_write_ready", DATA_W'(o_req_ready[0]), DATA_W'(1));
    @(posedge i_clk); #1;
    i_req_cmd[0]  = M_XRD;
    i_req_addr[0] = 56'h8000_0040;
    i_resp_ready  = '1;
    n = 0;
    while (accepts < 6 && n < 200) begin
      @(negedge i_clk);
      acc_b = o_req_ready[0];
      if (acc_b) begin
        sbPush(0, i_req_tag[0], D_AB, 1'b0);
        accepts++;
        last_ch = 0;
      end
      @(posedge i_clk); #1;
      n++;
      if (acc_b) i_req_tag[0] = i_req_tag[0] + 8'd1;
    end
    i_req_valid[0] = 1'b0;
    checkOutput("credit_total", DATA_W'(accepts), DATA_W'(6));
    waitDrain(200);
    applyStimulus(1, 1'b0, 56'h8000_0280, 8'h66, '0, '0, {64{8'hC3}}, 1'b1);
    waitDrain(50);
    @(negedge i_clk);
    checkOutput("addr_err_sticky", DATA_W'(o_addr_err), DATA_W'(1));
    @(posedge i_clk); #1;

    // Reset with three reads in flight: none may ever respond.
    applyStimulus(0, 1'b0, 56'h8000_0040, 8'h80, '0, '0, D_AB, 1'b0);
    applyStimulus(0, 1'b0, 56'h8000_0040, 8'h81, '0, '0, D_AB, 1'b0);
    applyStimulus(0, 1'b0, 56'h8000_0040, 8'h82, '0, '0, D_AB, 1'b0);
    i_reset = 1'b1;
    sb.delete();
    for (int c = 0; c < REQ_N; c++) begin
      i_req_valid[c] = 1'b1;
      i_req_cmd[c]   = M_XRD;
      i_req_addr[c]  = 56'h8000_0040;
    end
    i_req_tag[0] = 8'h70;
    i_req_tag[1] = 8'h71;
    @(negedge i_clk);
    checkOutput("rst2_req_ready", DATA_W'(o_req_ready), '0);
    checkOutput("rst2_resp_valid", DATA_W'(o_resp_valid), '0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    checkOutput("post_rst2_req_ready", DATA_W'(o_req_ready), '0);
    checkOutput("post_rst2_resp_valid", DATA_W'(o_resp_valid), '0);
    checkOutput("post_rst2_addr_err", DATA_W'(o_addr_err), '0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    got = o_req_ready & i_req_valid;
    checkOutput("rst_rr_ptr", DATA_W'(got), DATA_W'(1));
    if (got[0]) sbPush(0, 8'h70, D_AB, 1'b1);
    @(posedge i_clk); #1;
    i_req_valid = '0;
    waitDrain(50);
    repeat (20) @(posedge i_clk);
    #1;
    checkOutput("no_stray_resp", DATA_W'(sb.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
